// File: rtl/button_debounce_multi.sv
// N-channel button debouncer: per-channel 2-flop synchroniser, tick-based debounce counter,
// registered press/release/hold pulses, all channels sharing one millisecond tick prescaler.
module button_debounce_multi #(
    parameter int              SYSCLK_FREQ = 24000000,
    parameter int              N_CH        = 4,
    parameter int              DEBOUNCE_MS = 2,
    parameter int              HOLD_MS     = 1000,
    parameter logic [N_CH-1:0] ACTIVE_LOW  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] D,
    output logic [N_CH-1:0] Q,
    output logic [N_CH-1:0] press,
    // release pulse; "release" itself is a reserved word in SystemVerilog
    output logic [N_CH-1:0] rel,
    output logic [N_CH-1:0] hold
);

    localparam int TICK_DIV = SYSCLK_FREQ / 1000;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W     = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

    if (DEBOUNCE_MS < 1) begin : g_bad_debounce
        $error("button_debounce_multi: DEBOUNCE_MS must be >= 1");
    end
    if (TICK_DIV < 1) begin : g_bad_clk
        $error("button_debounce_multi: SYSCLK_FREQ must be >= 1000");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("button_debounce_multi: N_CH must be >= 1");
    end

    // Shared millisecond prescaler; tick is high during the last count, consumed at the wrap edge.
    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    assign tick = (ps_cnt == PS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // Synchroniser carries the polarity-corrected level, so reset means "released".
    logic [N_CH-1:0] sync_p0;
    logic [N_CH-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= D ^ ACTIVE_LOW;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DB_W-1:0] db_cnt;
        logic            q_r;
        logic            press_r;
        logic            rel_r;
        logic            differ;
        logic            flip;

        assign differ = (sync_p1[i] != q_r);
        assign flip   = differ && tick && (db_cnt == DB_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt  <= '0;
                q_r     <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                press_r <= flip &&  sync_p1[i];
                rel_r   <= flip && !sync_p1[i];
                if (flip) begin
                    q_r <= sync_p1[i];
                end
                if (!differ || flip) begin
                    db_cnt <= '0;
                end else if (tick) begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        assign Q[i]     = q_r;
        assign press[i] = press_r;
        assign rel[i]   = rel_r;

        if (HOLD_MS > 0) begin : g_hold
            localparam int              HOLD_W    = $clog2(HOLD_MS + 1);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_MS);

            logic [HOLD_W-1:0] hold_cnt;
            logic              hold_r;

            // Saturating at HOLD_MS keeps the pulse to once per press.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                    hold_r   <= 1'b0;
                end else begin
                    hold_r <= q_r && tick && (hold_cnt == HOLD_LAST);
                    if (!q_r) begin
                        hold_cnt <= '0;
                    end else if (tick && (hold_cnt != HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end

            assign hold[i] = hold_r;
        end else begin : g_no_hold
            assign hold[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: directed scenarios plus random per-channel bouncing,
// compared every cycle against a timestamp-based reference model.
module tb_button_debounce_multi;

    localparam int         TICK = 48;
    localparam int         DB   = 3;
    localparam int         HOLD = 10;
    localparam logic [3:0] AL   = 4'b0100;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D     = 4'b0100;
    logic [3:0] Q, press, rel, hold;

    button_debounce_multi #(
        .SYSCLK_FREQ (48000),
        .N_CH        (4),
        .DEBOUNCE_MS (DB),
        .HOLD_MS     (HOLD),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .Q     (Q),
        .press (press),
        .rel   (rel),
        .hold  (hold)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: edge index since reset, sync delay line, and per-channel timestamps.
    int         e;
    logic [3:0] m_s0, m_s1, m_q, m_press, m_rel, m_hold;
    int         diff_start [4];
    int         press_edge [4];
    int         n_press [4];
    int         n_rel   [4];
    int         n_hold  [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_s0 = '0; m_s1 = '0; m_q = '0;
        m_press = '0; m_rel = '0; m_hold = '0;
        for (int i = 0; i < 4; i++) begin
            diff_start[i] = 0;
            press_edge[i] = -1;
        end
    endtask

    // Q flips on a tick edge once DB ticks have fallen inside a continuous run of s != Q;
    // hold fires exactly HOLD ms-ticks of clocks after the press, if still pressed.
    task automatic model_edge(input logic [3:0] d_in);
        e++;
        for (int i = 0; i < 4; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_hold[i]  = m_q[i] && (press_edge[i] >= 0) && (e == press_edge[i] + HOLD * TICK);
            if (m_s1[i] != m_q[i]) begin
                if (diff_start[i] == 0) diff_start[i] = e;
                if ((e % TICK == 0) && (e / TICK - (diff_start[i] - 1) / TICK >= DB)) begin
                    m_q[i]        = m_s1[i];
                    m_press[i]    = m_s1[i];
                    m_rel[i]      = !m_s1[i];
                    diff_start[i] = 0;
                    press_edge[i] = m_s1[i] ? e : -1;
                end
            end else begin
                diff_start[i] = 0;
            end
        end
        m_s1 = m_s0;
        m_s0 = d_in ^ AL;
    endtask

    task automatic compare_all();
        check_eq("Q",     32'(Q),     32'(m_q));
        check_eq("press", 32'(press), 32'(m_press));
        check_eq("rel",   32'(rel),   32'(m_rel));
        check_eq("hold",  32'(hold),  32'(m_hold));
        for (int i = 0; i < 4; i++) begin
            n_press[i] += int'(press[i]);
            n_rel[i]   += int'(rel[i]);
            n_hold[i]  += int'(hold[i]);
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_hold[i] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(D);
        #1;
        compare_all();
    endtask

    task automatic run(input logic [3:0] d, input int n);
        D = d;
        repeat (n) cycle();
    endtask

    task automatic do_reset(input logic [3:0] d_val);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        D     = d_val;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] dr;
        int         dur [4];

        model_reset();
        clr_cnt();
        do_reset(4'b0100);
        run(4'b0100, 60);

        // Clean press held 15 ms, then release: one press, one hold, one release.
        clr_cnt();
        run(4'b0101, 720);
        run(4'b0100, 300);
        check_eq("s1_press0", 32'(n_press[0]), 32'd1);
        check_eq("s4_hold0",  32'(n_hold[0]),  32'd1);
        check_eq("s4_rel0",   32'(n_rel[0]),   32'd1);
        check_eq("s1_others", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);

        // Bounce on channel 1 every 30 clocks, then stable high.
        clr_cnt();
        for (int k = 0; k < 20; k++) run((k % 2 == 0) ? 4'b0110 : 4'b0100, 30);
        check_eq("s2_no_bounce_pulse", 32'(n_press[1] + n_rel[1]), 32'd0);
        run(4'b0110, 200);
        check_eq("s2_press1", 32'(n_press[1]), 32'd1);
        run(4'b0100, 200);

        // 60-clock glitch on channel 3.
        clr_cnt();
        run(4'b1100, 60);
        run(4'b0100, 200);
        check_eq("s3_glitch", 32'(n_press[3] + n_rel[3]), 32'd0);

        // Active-low channel 2.
        clr_cnt();
        run(4'b0000, 200);
        run(4'b0100, 200);
        check_eq("s5_press2", 32'(n_press[2]), 32'd1);
        check_eq("s5_rel2",   32'(n_rel[2]),   32'd1);

        // Reset 100 clocks into a debounce, input stays pressed.
        clr_cnt();
        run(4'b0101, 100);
        do_reset(4'b0101);
        run(4'b0101, 140);
        check_eq("s6_no_early_press", 32'(n_press[0]), 32'd0);
        run(4'b0101, 60);
        check_eq("s6_press0", 32'(n_press[0]), 32'd1);
        run(4'b0100, 200);

        // Simultaneous rise on channels 0 and 1.
        clr_cnt();
        run(4'b0111, 200);
        check_eq("s7_press01", 32'(n_press[0] + n_press[1]), 32'd2);
        check_eq("s7_others",  32'(n_press[2] + n_press[3]), 32'd0);
        run(4'b0100, 200);

        // Random bouncing with a mix of short glitches and long holds, plus one reset with Q likely set.
        dr = 4'b0100;
        for (int i = 0; i < 4; i++) dur[i] = int'($urandom_range(1, 300));
        for (int n = 0; n < 7000; n++) begin
            for (int i = 0; i < 4; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    dr[i]  = ~dr[i];
                    dur[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 40))
                                                         : int'($urandom_range(60, 900));
                end
            end
            if (n == 3500) begin
                do_reset(dr);
            end else begin
                D = dr;
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
